// File: rtl/pc_ir_regs.sv
// PC / IR register stage behind the multicycle control FSM, with misaligned-target
// trapping and a fetch counter. Define BRANCH_EXT_EN for the full funct3 branch table.
module pc_ir_regs #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCUpdate,
  input  logic             Branch,
  input  logic             IRWrite,
  input  logic [XLEN-1:0]  Result,
  input  logic [XLEN-1:0]  ReadData,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic             Zero,
  input  logic             Neg,
  input  logic             Ovf,
  input  logic             Carry,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  OldPC,
  output logic [XLEN-1:0]  Instr,
  output logic [6:0]       op,
  output logic [XLEN-1:0]  Data,
  output logic [XLEN-1:0]  ALUOut,
  output logic             PCWrite,
  output logic             MisalignTrap,
  output logic [CNT_W-1:0] FetchCount
);

  localparam logic [XLEN-1:0] NopInstr = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  old_pc_q, old_pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  data_q;
  logic [XLEN-1:0]  alu_out_q;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] funct3;
  logic       taken;
  logic       req;
  logic       misaligned;
  logic       fetch_en;

  assign funct3 = instr_q[14:12];

`ifdef BRANCH_EXT_EN
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Neg ^ Ovf;
      3'b101:  taken = !(Neg ^ Ovf);
      3'b110:  taken = !Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end
`else
  // beq only: the comparison flags and funct3 are intentionally ignored.
  logic unused_branch_ext;
  assign unused_branch_ext = ^{Neg, Ovf, Carry, funct3};
  assign taken = Zero;
`endif

  assign req        = PCUpdate | (Branch & taken);
  assign misaligned = req & (Result[1:0] != 2'b00);
  assign PCWrite    = req & !trap_q & (Result[1:0] == 2'b00);
  assign fetch_en   = IRWrite & !trap_q;

  always_comb begin
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    trap_d   = trap_q | misaligned;
    if (PCWrite) begin
      pc_d = Result;
    end
    // OldPC captures the pre-update PC even when PC is written in the same cycle.
    if (fetch_en) begin
      instr_d  = ReadData;
      old_pc_d = pc_q;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      old_pc_q  <= RESET_PC;
      instr_q   <= NopInstr;
      data_q    <= '0;
      alu_out_q <= '0;
      trap_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      instr_q   <= instr_d;
      data_q    <= ReadData;
      alu_out_q <= ALUResult;
      trap_q    <= trap_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PC           = pc_q;
  assign OldPC        = old_pc_q;
  assign Instr        = instr_q;
  assign op           = instr_q[6:0];
  assign Data         = data_q;
  assign ALUOut       = alu_out_q;
  assign MisalignTrap = trap_q;
  assign FetchCount   = cnt_q;

endmodule

// File: doc/pc_ir_regs.md
Name: pc_ir_regs

Overview:
- Architectural and non-architectural register stage directly downstream of the multicycle control FSM.
- Consumes the FSM's PCUpdate, Branch and IRWrite strobes plus ALU flags. Holds PC, OldPC, IR, Data and ALUOut.
- Produces PCWrite and feeds op back to the FSM. Adds misaligned-PC trapping and a fetch counter.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PC and OldPC value after reset.
- CNT_W, 32, width of fetch counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- PCUpdate  in  1  unconditional PC write request from FSM
- Branch  in  1  conditional branch evaluate strobe from FSM
- IRWrite  in  1  instruction register load strobe from FSM
- Result  in  XLEN  next-PC / writeback value from result mux
- ReadData  in  XLEN  memory read data
- ALUResult  in  XLEN  ALU output
- Zero, Neg, Ovf, Carry  in  1 each  ALU flags from A−B; Carry=1 means A≥B unsigned
- PC  out  XLEN  program counter
- OldPC  out  XLEN  PC of the instruction currently in IR
- Instr  out  XLEN  instruction register
- op  out  7  Instr[6:0], to FSM
- Data  out  XLEN  registered ReadData
- ALUOut  out  XLEN  registered ALUResult
- PCWrite  out  1  combinational effective PC write enable
- MisalignTrap  out  1  sticky misaligned-target flag
- FetchCount  out  CNT_W  count of accepted instruction fetches

Behaviour:
- Reset (reset==0 at posedge), overriding all other inputs, including mid-instruction:
  - PC=OldPC=RESET_PC
  - Instr=32'h0000_0013 (addi x0,x0,0; op=0010011)
  - Data=0, ALUOut=0, MisalignTrap=0, FetchCount=0
- taken (combinational, funct3=Instr[14:12]):
  - 000: Zero
  - 001: !Zero
  - 100: Neg^Ovf
  - 101: !(Neg^Ovf)
  - 110: !Carry
  - 111: Carry
  - 010/011: 0
- req = PCUpdate | (Branch & taken).
- PCWrite = req & !MisalignTrap & (Result[1:0]==2'b00). Combinational; no added latency.
- On posedge when PCWrite: PC <= Result.
- On posedge when IRWrite & !MisalignTrap:
  - Instr <= ReadData
  - OldPC <= PC (pre-update value, even if PCWrite in same cycle)
  - FetchCount <= FetchCount+1, wrapping from all-ones to 0
- Data <= ReadData and ALUOut <= ALUResult every non-reset cycle, unconditionally.
- Misalignment: if req & Result[1:0]!=0:
  - PC is not written.
  - MisalignTrap <= 1 next cycle.
  - The trap is sticky until reset.
- While MisalignTrap=1: PCWrite forced 0, IRWrite ignored, FetchCount frozen. Data and ALUOut still update.
- A misaligned req in the same cycle as IRWrite still loads Instr, OldPC and FetchCount that cycle, because the trap is not yet set.
- PCUpdate and Branch both high: OR semantics (PCUpdate dominates).
- op is a direct slice of Instr, with no extra register.

Optional Feature:
- Macro BRANCH_EXT_EN.
- Defined: full funct3 taken table as above (beq/bne/blt/bge/bltu/bgeu).
- Undefined: taken = Zero regardless of funct3 (beq only). Neg, Ovf and Carry are unused; ports remain present.

Test Plan:
- Reset: reset=0 for 2 cycles with PCUpdate=1, Result=0x40, IRWrite=1 -> PC=0, OldPC=0, Instr=0x00000013, op=0x13, FetchCount=0, MisalignTrap=0.
- Fetch: reset=1, PC=0, IRWrite=1, PCUpdate=1, Result=0x4, ReadData=0x00500093 -> next cycle PC=0x4, OldPC=0x0, Instr=0x00500093, op=0x13, FetchCount=1.
- beq: Instr funct3=000, Branch=1, Result=0x20:
  - Zero=1 -> PCWrite=1, PC=0x20.
  - Zero=0 -> PCWrite=0, PC unchanged.
- bltu: funct3=110, Branch=1, Carry=0, Zero=0, Result=0x100:
  - With BRANCH_EXT_EN -> PC=0x100.
  - Without -> PC unchanged.
  - funct3=011 -> never taken.
- Misaligned: PCUpdate=1, Result=0x22 -> PCWrite=0, PC unchanged, MisalignTrap=1 next cycle. Subsequent IRWrite=1 with ReadData=0xDEADBEEF leaves Instr and FetchCount unchanged. Data=0xDEADBEEF. reset=0 clears the trap.
- Wrap: CNT_W=4, 16 accepted fetches from reset -> FetchCount=0. Simultaneous IRWrite+PCWrite on every fetch gives OldPC = previous PC each time.
